// File: rtl/pcm_frame_sequencer.sv
// Frame capture controller behind the decimation chain: discards the filter transient,
// captures fixed-length PCM frames into a show-ahead FIFO and drains them as a valid/ready stream.
module pcm_frame_sequencer #(
  parameter int DW             = 16,
  parameter int FRAME_LEN      = 256,
  parameter int SETTLE_SAMPLES = 64,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic          CLKDIVH2,
  input  logic          RST,
  input  logic [DW-1:0] fir_in,
  input  logic          start,
  input  logic          stop,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          settled,
  output logic          busy,
  output logic          overflow,
  output logic [15:0]   frame_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = $clog2(FRAME_LEN);
  localparam int SW = $clog2(SETTLE_SAMPLES + 1);
  localparam logic [IW-1:0] LAST_IDX    = IW'(FRAME_LEN - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_SAMPLES - 1);

  typedef enum logic [1:0] {
    SETTLE  = 2'd0,
    IDLE    = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [SW-1:0]   settle_cnt_reg, settle_cnt_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [15:0]     frame_cnt_reg, frame_cnt_next;
  logic            overflow_reg, overflow_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;

  logic            fifo_empty;
  logic            fifo_full;
  logic            pop;
  logic            push_req;
  logic            push_ok;
  logic            push_last;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic [DW:0]     head;
  logic [DW:0]     entry_arr [FIFO_DEPTH];

  // Extra pointer MSB tells full from empty when the index bits match.
  assign wr_idx     = wr_ptr_reg[AW-1:0];
  assign rd_idx     = rd_ptr_reg[AW-1:0];
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_idx == rd_idx);
  assign pop        = !fifo_empty && m_ready;
  assign push_last  = (idx_reg == LAST_IDX);
  assign push_ok    = push_req && (!fifo_full || pop);

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic [DW:0] entry_reg;
      always_ff @(posedge CLKDIVH2) begin
        if (push_ok && (wr_idx == AW'(gi))) begin
          entry_reg <= {push_last, fir_in};
        end
      end
      assign entry_arr[gi] = entry_reg;
    end
  endgenerate

  assign head = entry_arr[rd_idx];

  // Head is masked while empty so the stream reads zero rather than stale storage.
  assign m_valid   = !fifo_empty;
  assign m_data    = fifo_empty ? '0 : head[DW-1:0];
  assign m_last    = !fifo_empty && head[DW];
  assign settled   = (state_reg != SETTLE);
  assign busy      = (state_reg == CAPTURE) || (state_reg == DRAIN);
  assign overflow  = overflow_reg;
  assign frame_cnt = frame_cnt_reg;

  always_ff @(posedge CLKDIVH2 or posedge RST) begin
    if (RST) begin
      state_reg      <= SETTLE;
      settle_cnt_reg <= '0;
      idx_reg        <= '0;
      frame_cnt_reg  <= '0;
      overflow_reg   <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      settle_cnt_reg <= settle_cnt_next;
      idx_reg        <= idx_next;
      frame_cnt_reg  <= frame_cnt_next;
      overflow_reg   <= overflow_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    settle_cnt_next = settle_cnt_reg;
    idx_next        = idx_reg;
    frame_cnt_next  = frame_cnt_reg;
    overflow_next   = overflow_reg;
    push_req        = 1'b0;
    case (state_reg)
      SETTLE: begin
        settle_cnt_next = settle_cnt_reg + SW'(1);
        if (settle_cnt_reg == SETTLE_LAST) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (start) begin
          state_next    = CAPTURE;
          overflow_next = 1'b0;
          idx_next      = '0;
        end
      end
      CAPTURE: begin
        if (stop) begin
          state_next = DRAIN;
        end else begin
          // A dropped slot still counts toward the frame length and frame count.
          push_req = 1'b1;
          idx_next = idx_reg + IW'(1);
          if (fifo_full && !pop) begin
            overflow_next = 1'b1;
          end
          if (push_last) begin
            frame_cnt_next = frame_cnt_reg + 16'd1;
            state_next     = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_next = IDLE;
        end
      end
      default: state_next = SETTLE;
    endcase
  end

  always_comb begin
    wr_ptr_next = push_ok ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
    rd_ptr_next = pop ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
  end

endmodule

// File: doc/pcm_frame_sequencer.md
Name: pcm_frame_sequencer

Overview:
- Capture controller at the output of the decimation chain (CIC -> HB1 -> HB2 -> F_FIR), clocked by the final decimated clock CLKDIVH2; one PCM sample is presented on every rising edge.
- After reset it discards the filter transient, then on command captures fixed-length frames of FIR output into a small FIFO.
- The FIFO is drained to a downstream consumer over a valid/ready stream with a last-sample marker.
- It is the sequencing point between the free-running filter datapath and the frame-based beamforming/storage logic.

Parameters:
- DW, 16, PCM sample width (matches FIR output)
- FRAME_LEN, 256, samples per frame (>=2)
- SETTLE_SAMPLES, 64, samples discarded after reset before capture is permitted (>=1)
- FIFO_DEPTH, 16, FIFO entries (power of 2, >=2)

Ports:
- CLKDIVH2 in 1: sample clock
- RST in 1: asynchronous, active-high reset
- fir_in in DW: signed PCM sample, new value every CLKDIVH2 edge
- start in 1: request one frame capture (level, sampled each edge)
- stop in 1: abort the frame in progress
- m_data out DW: stream data (FIFO head)
- m_last out 1: marks the final sample of a complete frame
- m_valid out 1: stream valid
- m_ready in 1: stream ready
- settled out 1: settle period finished
- busy out 1: high in CAPTURE or DRAIN
- overflow out 1: sticky, a captured sample was dropped
- frame_cnt out 16: completed frames, wraps at 65535->0

Behaviour:
- Reset (async, RST high): state=SETTLE; FIFO emptied; settle/sample counters=0; all outputs 0 (m_data=0, m_valid=0, m_last=0, settled=0, busy=0, overflow=0, frame_cnt=0). Reset mid-frame discards all FIFO contents and restarts the settle period.
- SETTLE:
  - Settle counter increments each edge.
  - After SETTLE_SAMPLES edges the state is IDLE and settled=1; settled stays 1 until the next reset.
  - start and stop are ignored.
- IDLE:
  - start=1 at edge k -> CAPTURE at edge k; overflow cleared at edge k; sample index=0.
  - fir_in at edge k is not captured.
- CAPTURE:
  - On each edge, fir_in is pushed with last=(index==FRAME_LEN-1), and index increments.
  - Samples are captured at edges k+1 .. k+FRAME_LEN.
  - After the push with index FRAME_LEN-1: frame_cnt+1, state -> DRAIN.
  - start is ignored while in CAPTURE.
- stop=1 in CAPTURE:
  - The sample at that edge is not pushed; state -> DRAIN.
  - frame_cnt is unchanged and no m_last is emitted.
  - stop takes priority over a same-edge final push.
- DRAIN: when the FIFO is empty (m_valid=0) -> IDLE on the next edge.
- FIFO:
  - Show-ahead: m_valid = not empty; m_data/m_last = head entry.
  - A sample pushed at edge j appears on m_data after edge j if the FIFO was empty (1-cycle latency).
  - Pop occurs on an edge with m_valid & m_ready.
  - Push is accepted if not full, or if full with a pop on the same edge; occupancy is then unchanged.
  - Push while full with no pop drops the sample and sets overflow=1 (sticky until next start or reset). The sample index still advances, so the frame stays FRAME_LEN sample slots long. If the dropped sample carried last, no m_last is emitted for that frame, but frame_cnt still increments.
  - Read/write pointers are log2(FIFO_DEPTH)+1 bits; full/empty are determined from the MSB comparison, and wrap-around is transparent.
- m_data/m_last must stay stable while m_valid=1 and m_ready=0.
- frame_cnt wraps modulo 2^16 without flagging.

Test Plan:
- Reset, SETTLE_SAMPLES=64, fir_in=ramp -> settled rises exactly after the 64th edge; start pulsed at edge 10 is ignored, busy stays 0.
- FRAME_LEN=8, FIFO_DEPTH=16, m_ready=1, fir_in=ramp with value n at edge n, start at edge 100 -> m_data shows 101..108 at consecutive edges, m_last only with 108, frame_cnt=1, busy falls one edge after the FIFO empties.
- FRAME_LEN=8, FIFO_DEPTH=4, m_ready=0 during capture -> first 4 samples retained, overflow=1, no m_last. Then m_ready=1 -> 4 samples drained, state returns to IDLE, frame_cnt=1. Next start clears overflow.
- FIFO full with m_ready=1 on the same edge as a push -> push accepted, occupancy stays 4, no overflow; pointers wrap correctly over 3 consecutive frames, verified data order.
- stop asserted at the 4th capture edge of FRAME_LEN=8 -> exactly 3 samples output, no m_last, frame_cnt unchanged, busy returns to 0.
- RST asserted mid-CAPTURE with 5 samples queued -> m_valid=0 immediately (async), settled=0, frame_cnt=0; a full settle period is required before the next start is accepted.
